nibble_swap_scheduler: RTL and testbench

Round-robin scheduler that shares one registered nibble-swap stage among `NREQ` requesters. Each requester offers a byte over a valid/ready handshake. The scheduler grants one requester at a time and drives the shared swap stage, applying the swap or passing the byte through according to that requester's `swap_mask` bit. The result is returned on a single output port with the winning requester's ID and downstream backpressure. The block sits between the byte producers and the consumer of swapped data, and replaces per-producer swapper instances.

---
 rtl/nibble_swap_scheduler.sv | 132 +++++++++++++
 tb/tb_nibble_swap_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_swap_scheduler.sv
// -----------------------------------------------------------------------------
// nibble_swap_scheduler
//
// Shares one registered nibble-swap stage among NREQ byte producers. A
// round-robin arbiter picks one requester, the captured byte is swapped (or
// passed through, per that requester's swap_mask bit) in a one-cycle SWAP
// state, and the result is held on a single output port until the consumer
// takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds valid and data stable
// until that edge; ready never depends on the data being offered.
//
// Ports:
//   clk        clock, rising edge active
//   reset_n    asynchronous active-low reset
//   req_valid  [NREQ]    per-requester request valid
//   req_data   [8*NREQ]  per-requester byte, requester i at [8i+7:8i]
//   req_ready  [NREQ]    one-hot (or zero) accept, combinational
//   swap_mask  [NREQ]    1 = swap nibbles for requester i, sampled at accept
//   out_valid            result valid (state HOLD)
//   out_data   [8]       result byte, keeps last value after transfer
//   out_id     [IDW]     requester that produced out_data
//   out_ready            consumer accepts the result
//   busy                 state is not IDLE
//   dbg_state  [2]       current FSM state encoding (IDLE=0, SWAP=1, HOLD=2)
// -----------------------------------------------------------------------------
module nibble_swap_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   swap_mask,
   output logic              out_valid,
   output logic [7:0]        out_data,
   output logic [IDW-1:0]    out_id,
   input  logic              out_ready,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SWAP = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] idx;
   logic           found;
   logic           arb_en;
   logic           accept;
   logic [7:0]     cap_data;
   logic           cap_mask;
   logic [IDW-1:0] cap_id;

   // Round-robin search starting at ptr. NREQ is a power of two, so the
   // IDW-bit addition wraps modulo NREQ for free.
   always_comb begin
      arb_en = (state == IDLE) || ((state == HOLD) && out_ready);
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr + IDW'(k);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      // reset_n gates the grant so no requester sees an accept during reset.
      accept    = reset_n && arb_en && found;
      req_ready = '0;
      if (accept) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = SWAP;
         SWAP: state_nxt = HOLD;
         HOLD: begin
            if (out_ready) begin
               state_nxt = accept ? SWAP : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         ptr      <= '0;
         cap_data <= '0;
         cap_mask <= 1'b0;
         cap_id   <= '0;
         out_data <= '0;
         out_id   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cap_data <= req_data[{winner, 3'b000} +: 8];
            cap_mask <= swap_mask[winner];
            cap_id   <= winner;
            ptr      <= winner + IDW'(1);
         end
         // Output registers only load in SWAP, so they hold through HOLD and
         // keep their last value afterwards.
         if (state == SWAP) begin
            out_data <= cap_mask ? {cap_data[3:0], cap_data[7:4]} : cap_data;
            out_id   <= cap_id;
         end
      end
   end

   // Derived from the state register, so an asynchronous reset drops
   // out_valid and busy immediately.
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_nibble_swap_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nibble_swap_scheduler
//
// Bench for nibble_swap_scheduler (NREQ=4). Directed phases and random
// traffic drive the requester and consumer sides; a negedge monitor keeps a
// slot-occupancy reference model (what is being swapped, what is held),
// predicts the round-robin grant, pushes the expected {id, byte} on accept
// and compares the output port against the queue front.
// -----------------------------------------------------------------------------
module tb_nibble_swap_scheduler;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int W    = IDW + 8;

   logic              clk;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   swap_mask;
   logic              out_valid;
   logic [7:0]        out_data;
   logic [IDW-1:0]    out_id;
   logic              out_ready;
   logic              busy;
   logic [1:0]        dbg_state;

   nibble_swap_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .swap_mask (swap_mask),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters / model state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int n_xfer   = 0;

   logic [W-1:0]    exp_q[$];
   int              m_ptr  = 0;
   bit              m_swap = 1'b0;
   bit              m_held = 1'b0;
   logic [NREQ-1:0] last_rdy = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (p + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [7:0] ref_result(input logic [7:0] d, input logic m);
      logic [7:0] r;
      r = m ? 8'((d << 4) | (d >> 4)) : d;
      return r;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      int         w;
      logic [7:0] d;
      if (!reset_n) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_out_data", out_data, 0);
         check("rst_out_id", out_id, 0);
         check("rst_req_ready", req_ready, 0);
         check("rst_busy", busy, 0);
         exp_q.delete();
         m_ptr    = 0;
         m_swap   = 1'b0;
         m_held   = 1'b0;
         last_rdy = '0;
      end else begin
         check("out_valid", out_valid, m_held);
         check("busy", busy, m_swap || m_held);
         if (m_held) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL queue_empty: result held with nothing expected at %0t", $time);
            end else begin
               check("out_id", out_id, exp_q[0][W-1:8]);
               check("out_data", out_data, exp_q[0][7:0]);
            end
         end
         w = (!m_swap && (!m_held || out_ready)) ? rr_pick(m_ptr, req_valid) : -1;
         check("req_ready", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
         last_rdy = req_ready;
         // advance the model to the state after the coming edge
         if (m_held && out_ready) begin
            void'(exp_q.pop_front());
            n_xfer++;
         end
         m_held = m_swap || (m_held && !out_ready);
         m_swap = (w >= 0);
         if (w >= 0) begin
            d = req_data[w*8 +: 8];
            exp_q.push_back({IDW'(w), ref_result(d, swap_mask[w])});
            m_ptr = (w + 1) % NREQ;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_accept(input int i, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (last_rdy == '0 && n < 20);
      check(name, last_rdy, 32'd1 << i);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_reset(input int cycles);
      reset_n = 1'b0;
      repeat (cycles) begin
         @(posedge clk); #1;
         req_valid = NREQ'($urandom);
         req_data  = 32'($urandom);
         swap_mask = NREQ'($urandom);
         out_ready = 1'($urandom);
      end
      req_valid = '0;
      out_ready = 1'b1;
      reset_n   = 1'b1;
   endtask

   task automatic single(input logic m, input string name);
      req_valid = 4'b0100;
      req_data  = 32'h00D5_0000;
      swap_mask = {1'b0, m, 2'b00};
      out_ready = 1'b1;
      wait_accept(2, name);
      req_valid = '0;
      idle_cycles(4);
   endtask

   task automatic run_random(input int cycles, input int pv, input int pr);
      logic [NREQ-1:0]   v;
      logic [8*NREQ-1:0] d;
      v = req_valid;
      d = req_data;
      repeat (cycles) begin
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] || last_rdy[i]) begin
               v[i]         = ($urandom_range(0, 99) < pv);
               d[i*8 +: 8]  = 8'($urandom);
            end
         end
         req_valid = v;
         req_data  = d;
         swap_mask = NREQ'($urandom);
         out_ready = ($urandom_range(0, 99) < pr);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n   = 1'b1;
      req_valid = '0;
      req_data  = '0;
      swap_mask = '0;
      out_ready = 1'b0;
      #1;
      pulse_reset(4);

      // single swap and pass-through from requester 2
      single(1'b1, "single_swap_acc");
      single(1'b0, "pass_thru_acc");

      // round robin with wrap, all requesters permanently valid
      pulse_reset(2);
      req_data  = 32'h4332_2110;
      swap_mask = 4'b1111;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      idle_cycles(14);
      req_valid = '0;
      idle_cycles(4);

      // backpressure: requester 1 waits while the result is held
      out_ready = 1'b0;
      req_data  = 32'h0000_3CA7;
      swap_mask = 4'b0001;
      req_valid = 4'b0001;
      wait_accept(0, "bp_acc0");
      req_valid = 4'b0010;
      swap_mask = 4'b1110;
      idle_cycles(6);
      out_ready = 1'b1;
      wait_accept(1, "bp_acc1");
      req_valid = '0;
      idle_cycles(4);

      // random traffic at several load / backpressure mixes
      run_random(1500, 60, 70);
      run_random(1000, 95, 100);
      run_random(1000, 30, 25);
      req_valid = '0;
      out_ready = 1'b1;
      idle_cycles(4);

      // reset during SWAP
      out_ready = 1'b0;
      req_data  = 32'h00E1_0000;
      req_valid = 4'b0100;
      wait_accept(2, "mid_acc_swap");
      req_valid = '0;
      #2 reset_n = 1'b0;
      #1;
      check("mid_swap_out_valid", out_valid, 0);
      check("mid_swap_busy", busy, 0);
      check("mid_swap_req_ready", req_ready, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // reset during HOLD
      req_data  = 32'h0000_7700;
      req_valid = 4'b0010;
      wait_accept(1, "mid_acc_hold");
      req_valid = '0;
      @(posedge clk); #1;
      check("hold_out_valid_before", out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_hold_out_valid", out_valid, 0);
      check("mid_hold_out_data", out_data, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // after release arbitration restarts at requester 0
      req_data  = 32'h9A00_005B;
      swap_mask = 4'b1001;
      out_ready = 1'b1;
      req_valid = 4'b1001;
      wait_accept(0, "post_rst_first");
      req_valid = 4'b1000;
      wait_accept(3, "post_rst_second");
      req_valid = '0;
      idle_cycles(6);

      check("drain_empty", exp_q.size(), 0);
      check("transfers_seen", (n_xfer > 200), 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
